// File: rtl/fpmul_pkg.sv
// Shared definitions for the binary32 multiplier issue controller:
// FSM encoding, operand class codes and out_flags bit positions.
package fpmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUBN = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_class_t;

   localparam int FP_W  = 32;
   localparam int CNT_W = 4;

   localparam int FLAG_ZERO    = 0;
   localparam int FLAG_INF     = 1;
   localparam int FLAG_NAN     = 2;
   localparam int FLAG_INVALID = 3;

endpackage

// File: rtl/fp_classify.sv
// Classifies one binary32 value; subnormals are reported as SUBN, never ZERO.
module fp_classify
   import fpmul_pkg::*;
(
   input  logic [FP_W-1:0] x,
   output fp_class_t       cls
);

   logic [7:0]  expo;
   logic [22:0] frac;

   assign expo = x[30:23];
   assign frac = x[22:0];

   always_comb begin
      cls = CLS_NORM;
      if (expo == 8'h00) begin
         cls = (frac == 23'd0) ? CLS_ZERO : CLS_SUBN;
      end else if (expo == 8'hFF) begin
         if (frac == 23'd0)  cls = CLS_INF;
         else if (frac[22])  cls = CLS_QNAN;
         else                cls = CLS_SNAN;
      end
   end

endmodule

// File: rtl/fpmul_issue_ctrl.sv
// Issue/handshake controller around an external fixed-latency binary32 multiplier;
// holds operands stable, captures the product and its exception flags.
module fpmul_issue_ctrl
   import fpmul_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] in_a,
   input  logic [FP_W-1:0] in_b,
   output logic [FP_W-1:0] mul_a,
   output logic [FP_W-1:0] mul_b,
   input  logic [FP_W-1:0] mul_z,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] out_z,
   output logic [3:0]      out_flags
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             rdy_en;
   logic             accept;
   logic             capture;
   fp_class_t        cls_a, cls_b;

   fp_classify u_cls_a (.x(mul_a), .cls(cls_a));
   fp_classify u_cls_b (.x(mul_b), .cls(cls_b));

   function automatic logic [3:0] calc_flags(input fp_class_t ca, input fp_class_t cb,
                                             input logic [FP_W-1:0] z);
      logic [3:0] f;
      logic       inf_zero;
      inf_zero = ((ca == CLS_INF) && (cb == CLS_ZERO)) || ((ca == CLS_ZERO) && (cb == CLS_INF));
      f = '0;
      f[FLAG_INVALID] = (ca == CLS_SNAN) || (cb == CLS_SNAN) || inf_zero;
      f[FLAG_NAN]     = (ca == CLS_QNAN) || (ca == CLS_SNAN) ||
                        (cb == CLS_QNAN) || (cb == CLS_SNAN) || inf_zero;
      f[FLAG_INF]     = (((ca == CLS_INF) || (cb == CLS_INF)) && !f[FLAG_NAN]) ||
                        ((z[30:23] == 8'hFF) && (z[22:0] == 23'd0));
      f[FLAG_ZERO]    = (z[30:0] == 31'd0);
      return f;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // rdy_en keeps in_ready low until the first edge after reset release
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = rdy_en;
               if (in_valid && rdy_en) begin
                  accept    = 1'b1;
                  state_nxt = WAIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en    <= 1'b0;
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         out_z     <= '0;
         out_flags <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
            cnt   <= CNT_INIT;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            out_z     <= mul_z;
            out_flags <= calc_flags(cls_a, cls_b, mul_z);
         end
      end
   end

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Bench for fpmul_issue_ctrl: three instances (MUL_LAT 1, 2, 15) share stimulus and
// are each compared every cycle against a timestamp-based transaction model.
module tb_fpmul_issue_ctrl;

   localparam int N = 3;
   localparam int LATS[N] = '{1, 2, 15};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_a, in_b;
   logic        in_ready[N];
   logic        out_valid[N];
   logic [31:0] mul_a[N], mul_b[N], mul_z[N], out_z[N];
   logic [3:0]  out_flags[N];
   logic [31:0] pipe[N][15];

   always #5 clk = ~clk;

   fpmul_issue_ctrl #(.MUL_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_z(mul_z[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_z(out_z[0]), .out_flags(out_flags[0]));
   fpmul_issue_ctrl #(.MUL_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_z(mul_z[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_z(out_z[1]), .out_flags(out_flags[1]));
   fpmul_issue_ctrl #(.MUL_LAT(15)) u_lat15 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_z(mul_z[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready), .out_z(out_z[2]), .out_flags(out_flags[2]));

   // Stand-in multiplier: known products for the directed pairs, a scramble otherwise
   function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40000000, 32'h40400000}: return 32'h40C00000;
         {32'h7F800000, 32'h00000000}: return 32'h7FC00000;
         {32'h00000000, 32'h7F800000}: return 32'h7FC00000;
         {32'h7F800001, 32'h3F800000}: return 32'h7FC00001;
         {32'h00000001, 32'h3F800000}: return 32'h00000000;
         {32'h00000001, 32'h7F800000}: return 32'h7F800000;
         {32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
         {32'hFF800000, 32'h40000000}: return 32'hFF800000;
         {32'h80000000, 32'h40000000}: return 32'h80000000;
         {32'h3F800000, 32'h00000001}: return 32'h00000001;
         default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
      endcase
   endfunction

   // Result is only correct once operands have been stable MUL_LAT cycles
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         pipe[i][0] <= mul_fn(mul_a[i], mul_b[i]);
         for (int k = 1; k < 15; k++) pipe[i][k] <= pipe[i][k-1];
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (LATS[i] == 1) mul_z[i] = mul_fn(mul_a[i], mul_b[i]);
         else              mul_z[i] = pipe[i][(LATS[i] >= 2) ? LATS[i] - 2 : 0];
      end
   end

   function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] z);
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv, nan, inf;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = (a[30:0] == 0);
      b_zero = (b[30:0] == 0);
      inv = (a_nan && !a[22]) || (b_nan && !b[22]) || (a_inf && b_zero) || (a_zero && b_inf);
      nan = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      inf = ((a_inf || b_inf) && !nan) || ((z[30:23] == 8'hFF) && (z[22:0] == 0));
      return {inv, nan, inf, (z[30:0] == 0)};
   endfunction

   // Transaction model: accept at cycle c makes the result visible from cycle c+LAT+1
   int          cyc;
   bit          m_en;
   bit          m_pend[N];
   bit          m_hold[N];
   int          m_ready_at[N];
   logic [31:0] m_a[N], m_b[N], m_z[N];
   logic [3:0]  m_f[N];
   int          nchk, nerr;

   task automatic chk(input string name, input int i, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s lat=%0d cyc=%0d t=%0t got=%h exp=%h", name, LATS[i], cyc, $time, got, exp);
      end
   endtask

   function automatic bit exp_rdy(input int i);
      return m_en && !m_pend[i] && (!m_hold[i] || out_ready);
   endfunction

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         bit acc;
         acc = in_valid && exp_rdy(i);
         if (m_hold[i] && out_ready) m_hold[i] = 0;
         if (m_pend[i] && (cyc + 1 == m_ready_at[i])) begin
            m_pend[i] = 0;
            m_hold[i] = 1;
            m_z[i] = mul_fn(m_a[i], m_b[i]);
            m_f[i] = ref_flags(m_a[i], m_b[i], m_z[i]);
         end
         if (acc) begin
            m_pend[i] = 1;
            m_a[i] = in_a;
            m_b[i] = in_b;
            m_ready_at[i] = cyc + 1 + LATS[i];
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("out_valid", i, 32'(out_valid[i]), 32'(m_hold[i]));
         chk("in_ready", i, 32'(in_ready[i]), 32'(exp_rdy(i)));
         if (m_hold[i]) begin
            chk("out_z", i, out_z[i], m_z[i]);
            chk("out_flags", i, 32'(out_flags[i]), 32'(m_f[i]));
         end
         if (m_pend[i]) begin
            chk("mul_a_hold", i, mul_a[i], m_a[i]);
            chk("mul_b_hold", i, mul_b[i], m_b[i]);
         end
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
         chk("rst_in_ready", i, 32'(in_ready[i]), 32'd0);
         chk("rst_out_z", i, out_z[i], 32'd0);
         chk("rst_out_flags", i, 32'(out_flags[i]), 32'd0);
         chk("rst_mul_a", i, mul_a[i], 32'd0);
         m_pend[i] = 0;
         m_hold[i] = 0;
      end
      m_en = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++) chk("rel_in_ready_low", i, 32'(in_ready[i]), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) chk("rel_in_ready_high", i, 32'(in_ready[i]), 32'd1);
      m_en = 1;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic [3:0]  f;
   } vec_t;

   vec_t        tbl[10];
   logic [31:0] pool[10];
   logic [31:0] hold_z;
   logic [3:0]  hold_f;
   int          last, acc_cyc;
   int          first_seen[N];

   initial begin
      tbl[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
      tbl[1] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1100};
      tbl[2] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1100};
      tbl[3] = '{32'h7F800001, 32'h3F800000, 32'h7FC00001, 4'b1100};
      tbl[4] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001};
      tbl[5] = '{32'h00000001, 32'h7F800000, 32'h7F800000, 4'b0010};
      tbl[6] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100};
      tbl[7] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0010};
      tbl[8] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0001};
      tbl[9] = '{32'h3F800000, 32'h00000001, 32'h00000001, 4'b0000};
      pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
               32'h7F800001, 32'h00000001, 32'h3F800000, 32'h40000000, 32'h40400000};
      nchk = 0; nerr = 0; cyc = 0; m_en = 0;
      in_valid = 0; out_ready = 1; in_a = 0; in_b = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_hold[i] = 0; m_ready_at[i] = 0;
      end

      do_reset();

      // Directed vectors; MUL_LAT=2 result must appear exactly 3 cycles after accept
      for (int v = 0; v < 10; v++) begin
         in_valid = 1; in_a = tbl[v].a; in_b = tbl[v].b;
         step();
         in_valid = 0;
         step();
         step();
         chk("vec_valid", 1, 32'(out_valid[1]), 32'd1);
         chk("vec_z", 1, out_z[1], tbl[v].z);
         chk("vec_flags", 1, 32'(out_flags[1]), 32'(tbl[v].f));
         repeat (16) step();
      end

      // Latency of each instance from accept cycle to first out_valid cycle
      out_ready = 0;
      in_valid = 1; in_a = 32'h3F800000; in_b = 32'h40400000;
      acc_cyc = cyc;
      step();
      in_valid = 0;
      for (int i = 0; i < N; i++) first_seen[i] = -1;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++)
            if (out_valid[i] && first_seen[i] < 0) first_seen[i] = cyc - acc_cyc;
         step();
      end
      for (int i = 0; i < N; i++) chk("latency", i, 32'(first_seen[i]), 32'(LATS[i] + 1));
      out_ready = 1;
      repeat (3) step();

      // Back-pressure: result frozen, second request refused until out_ready
      out_ready = 0;
      in_valid = 1; in_a = 32'h3F800000; in_b = 32'h40000000;
      step();
      in_valid = 0;
      step();
      step();
      hold_z = out_z[1];
      hold_f = out_flags[1];
      in_valid = 1; in_a = 32'h40400000; in_b = 32'h40000000;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_valid", 1, 32'(out_valid[1]), 32'd1);
         chk("bp_in_ready", 1, 32'(in_ready[1]), 32'd0);
         chk("bp_z_stable", 1, out_z[1], hold_z);
         chk("bp_flags_stable", 1, 32'(out_flags[1]), 32'(hold_f));
      end
      out_ready = 1;
      step();
      in_valid = 0;
      repeat (20) step();

      // Back-to-back: continuous traffic, fresh operands every cycle
      in_valid = 1;
      last = -1;
      for (int k = 0; k < 40; k++) begin
         in_a = pool[$urandom % 10];
         in_b = $urandom;
         if (out_valid[1]) begin
            if (last >= 0) chk("b2b_period", 1, 32'(cyc - last), 32'd3);
            last = cyc;
         end
         step();
      end
      in_valid = 0;
      repeat (20) step();

      // Random traffic and back-pressure
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom % 2) == 0;
         out_ready = ($urandom % 4) != 0;
         in_a = (($urandom % 3) == 0) ? $urandom : pool[$urandom % 10];
         in_b = (($urandom % 3) == 0) ? $urandom : pool[$urandom % 10];
         step();
      end
      in_valid = 0; out_ready = 1;
      repeat (20) step();

      // Asynchronous reset between edges while results are in flight
      out_ready = 0;
      in_valid = 1; in_a = 32'h40000000; in_b = 32'h40400000;
      step();
      in_valid = 0;
      step();
      chk("pre_rst_valid", 0, 32'(out_valid[0]), 32'd1);
      #2;
      do_reset();
      out_ready = 1;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
